// File: rtl/fm_mpx_pkg.sv
// fm_mpx_pkg: shared widths, FSM states, saturation and sine-table helpers for the MPX composer
package fm_mpx_pkg;
    localparam int DW_D   = 18;
    localparam int SW_D   = 8;
    localparam int KPW_D  = 4;
    localparam int KFW_D  = 8;
    localparam int OW_D   = 24;
    localparam int PHW_D  = 18;
    localparam int LUTA_D = 6;
    localparam int PSH_D  = 6;
    localparam int FSH_D  = 4;
    localparam logic [17:0] PINC_D = 18'h06555;

    typedef enum logic [2:0] {S_IDLE, S_MUL_P, S_MUL_S, S_SUM, S_MUL_F, S_OUT} state_t;

    // Clamp a signed value into the range of a w-bit two's complement word.
    function automatic longint sat(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
    endfunction

    // round(amp*sin(2*pi*k/2^la)) in pure integer math: quadrant folding plus a Q30 Taylor series.
    function automatic int sine_lut(input int k, input int la, input int amp);
        longint n, kk, x, s, t, r;
        bit neg;
        n = longint'(1) << la;
        kk = longint'(k) % n;
        neg = kk >= n / 2;
        if (neg) kk = kk - n / 2;
        if (kk > n / 4) kk = n / 2 - kk;
        x = (64'sd3373259426 * 2 * kk) / n;
        s = x;
        t = x;
        for (int i = 1; i <= 6; i++) begin
            t = -((((t * x) >>> 30) * x) >>> 30) / longint'((2 * i) * (2 * i + 1));
            s = s + t;
        end
        r = (s * amp + (longint'(1) << 29)) >>> 30;
        return int'(neg ? -r : r);
    endfunction
endpackage

// File: rtl/fm_mpx_composer_mult.sv
// mpx_seqmult: signed radix-2 shift-add multiplier, done pulses exactly BW+1 cycles after start
module mpx_seqmult #(
    parameter int AW = 20,
    parameter int BW = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [AW+BW-1:0] p,
    output logic                 done
);
    localparam int PW = AW + BW;
    localparam int CW = $clog2(BW + 1);

    logic signed [PW-1:0] r_a, r_acc;
    logic [BW-1:0] r_b;
    logic [CW-1:0] r_cnt;
    logic r_run, r_done;
    logic signed [PW-1:0] w_term;
    logic w_last;

    assign w_term = r_b[0] ? r_a : '0;
    assign w_last = r_cnt == CW'(BW - 1);
    assign p = r_acc;
    assign done = r_done;

    // Load on start, then add one partial product per cycle; the sign bit of b has negative weight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a <= PW'(a);
                r_b <= b;
                r_acc <= '0;
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_acc <= w_last ? r_acc - w_term : r_acc + w_term;
                r_a <= r_a <<< 1;
                r_b <= r_b >> 1;
                r_cnt <= r_cnt + 1'b1;
                r_run <= !w_last;
                r_done <= w_last;
            end
        end
    end
endmodule

// File: rtl/fm_mpx_composer.sv
// fm_mpx_composer: builds mono + Kp*pilot + diff*subcarrier, scales by Kf into the FM frequency word
module fm_mpx_composer
    import fm_mpx_pkg::*;
#(
    parameter int DW   = DW_D,
    parameter int SW   = SW_D,
    parameter int KPW  = KPW_D,
    parameter int KFW  = KFW_D,
    parameter int OW   = OW_D,
    parameter int PHW  = PHW_D,
    parameter int LUTA = LUTA_D,
    parameter logic [PHW-1:0] PINC = PINC_D,
    parameter int PSH  = PSH_D,
    parameter int FSH  = FSH_D
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clken,
    input  logic signed [DW-1:0]  mono,
    input  logic signed [DW-1:0]  diff,
    input  logic [KPW-1:0]        kp,
    input  logic [KFW-1:0]        kf,
    input  logic                  stereo_en,
    output logic signed [OW-1:0]  fm_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);
    localparam int B1   = (KPW + 1 > SW) ? KPW + 1 : SW;
    localparam int BMAX = (B1 > KFW + 1) ? B1 : KFW + 1;
    localparam int AMAX = DW + 2;
    localparam int PW   = AMAX + BMAX;

    state_t r_state, w_next;
    logic [PHW-1:0] r_phase;
    logic signed [DW-1:0] r_mono, r_diff, r_pterm, r_sterm;
    logic [KPW-1:0] r_kp;
    logic [KFW-1:0] r_kf;
    logic r_st, r_go, r_overrun;
    logic signed [SW-1:0] r_pilot, r_sub;
    logic signed [OW-1:0] r_fm;
    logic signed [SW-1:0] w_lut [1<<LUTA];
    logic signed [AMAX-1:0] w_sum, w_ma;
    logic signed [BMAX-1:0] w_mb;
    logic signed [PW-1:0] w_prod;
    logic w_start, w_done, w_accept;

    for (genvar k = 0; k < (1 << LUTA); k++) begin : g_lut
        assign w_lut[k] = SW'(sine_lut(k, LUTA, (1 << (SW - 1)) - 1));
    end

    // In mono mode the pilot and subcarrier terms are dropped but the multiplies still run.
    assign w_sum = AMAX'(r_mono) + (r_st ? AMAX'(r_pterm) + AMAX'(r_sterm) : AMAX'(0));
    assign w_accept = r_state == S_IDLE && clken;
    assign w_start = r_go || (r_state == S_MUL_P && w_done) || r_state == S_SUM;
    assign w_ma = r_go ? AMAX'($signed({1'b0, r_kp})) : r_state == S_MUL_P ? AMAX'(r_diff) : w_sum;
    assign w_mb = r_go ? BMAX'(r_pilot) : r_state == S_MUL_P ? BMAX'(r_sub) : BMAX'($signed({1'b0, r_kf}));
    assign fm_out = r_fm;
    assign out_valid = r_state == S_OUT;
    assign busy = r_state != S_IDLE;
    assign overrun = r_overrun;

    mpx_seqmult #(.AW(AMAX), .BW(BMAX)) u_mult (
        .clock(clock),
        .reset(reset),
        .start(w_start),
        .a(w_ma),
        .b(w_mb),
        .p(w_prod),
        .done(w_done)
    );

    // Sample sequencing: three chained multiplies with a one-cycle sum step before the last.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (clken) w_next = S_MUL_P;
            S_MUL_P: if (w_done) w_next = S_MUL_S;
            S_MUL_S: if (w_done) w_next = S_SUM;
            S_SUM:   w_next = S_MUL_F;
            S_MUL_F: if (w_done) w_next = S_OUT;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        r_state <= reset ? S_IDLE : w_next;
    end

    // Sample capture, phase accumulation, per-step product scaling and the sticky overrun flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= '0;
            r_mono <= '0;
            r_diff <= '0;
            r_kp <= '0;
            r_kf <= '0;
            r_st <= 1'b0;
            r_pilot <= '0;
            r_sub <= '0;
            r_pterm <= '0;
            r_sterm <= '0;
            r_fm <= '0;
            r_go <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_go <= w_accept;
            if (clken && r_state != S_IDLE) r_overrun <= 1'b1;
            if (w_accept) begin
                r_mono <= mono;
                r_diff <= diff;
                r_kp <= kp;
                r_kf <= kf;
                r_st <= stereo_en;
                r_pilot <= w_lut[r_phase[PHW-1 -: LUTA]];
                r_sub <= w_lut[r_phase[PHW-2 -: LUTA]];
                r_phase <= r_phase + PINC;
            end
            if (w_done && r_state == S_MUL_P) r_pterm <= DW'(sat(longint'(w_prod) <<< PSH, DW));
            if (w_done && r_state == S_MUL_S) r_sterm <= DW'(w_prod >>> SW);
            if (w_done && r_state == S_MUL_F) r_fm <= OW'(sat(longint'(w_prod >>> FSH), OW));
        end
    end
endmodule

// File: tb/tb_fm_mpx_composer.sv
// tb_fm_mpx_composer: directed vector table, overrun/reset/saturation sequences and a reference-model sweep
module tb_fm_mpx_composer;
    logic clock = 1'b0, reset = 1'b1;
    logic clken = 1'b0, stereo_en = 1'b0, clken2 = 1'b0, stereo2 = 1'b0;
    logic signed [17:0] mono = '0, diff = '0, mono2 = '0, diff2 = '0;
    logic [3:0] kp = '0, kp2 = '0;
    logic [7:0] kf = '0, kf2 = '0;
    logic signed [23:0] fm_out, fm_out2;
    logic out_valid, busy, overrun, out_valid2, busy2, overrun2;
    int n_tests = 0, n_fail = 0, n_samp = 0;
    longint got;
    int lat, np;
    logic signed [17:0] rm, rd;
    logic [3:0] rp;
    logic [7:0] rf;
    logic rs;

    typedef struct {
        logic signed [17:0] m;
        logic signed [17:0] d;
        logic [3:0] p;
        logic [7:0] f;
        logic s;
        longint exp;
    } vec_t;
    vec_t tbl [7];

    always #5 clock = ~clock;

    fm_mpx_composer dut (
        .clock(clock), .reset(reset), .clken(clken), .mono(mono), .diff(diff),
        .kp(kp), .kf(kf), .stereo_en(stereo_en), .fm_out(fm_out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    fm_mpx_composer #(.FSH(0)) dut_sat (
        .clock(clock), .reset(reset), .clken(clken2), .mono(mono2), .diff(diff2),
        .kp(kp2), .kf(kf2), .stereo_en(stereo2), .fm_out(fm_out2),
        .out_valid(out_valid2), .busy(busy2), .overrun(overrun2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat_m(input longint v, input int w);
        longint hi;
        hi = (longint'(1) << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic int lut_m(input int i);
        return int'(127.0 * $sin(2.0 * 3.141592653589793 * i / 64.0));
    endfunction

    function automatic longint model(input int n, input longint m, input longint d, input longint p, input longint f, input bit s);
        longint ph, pt, st, sum;
        ph = (longint'(n) * 25941) % 262144;
        pt = sat_m(longint'(lut_m(int'(ph >> 12))) * p * 64, 18);
        st = (d * lut_m(int'(((2 * ph) % 262144) >> 12))) >>> 8;
        sum = s ? m + pt + st : m;
        return sat_m((sum * f) >>> 4, 24);
    endfunction

    task automatic sample(input logic signed [17:0] m, input logic signed [17:0] d, input logic [3:0] p,
                          input logic [7:0] f, input logic s, output longint g, output int l, output int n, output int gl);
        logic signed [23:0] prev;
        mono = m; diff = d; kp = p; kf = f; stereo_en = s; clken = 1'b1;
        g = 0; l = -1; n = 0; gl = 0; prev = fm_out;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            clken = 1'b0;
            if (out_valid) begin
                n++;
                if (l < 0) l = k;
                g = fm_out;
            end else if (fm_out != prev) gl++;
            prev = fm_out;
        end
    endtask

    task automatic run(input string name, input logic signed [17:0] m, input logic signed [17:0] d,
                       input logic [3:0] p, input logic [7:0] f, input logic s, input longint exp);
        longint g;
        int l, n, gl;
        sample(m, d, p, f, s, g, l, n, gl);
        check(name, g, exp);
        check({name, "_latency"}, l, 33);
        check({name, "_pulses"}, n, 1);
        check({name, "_hold"}, gl, 0);
        n_samp++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{18'sd1000, 18'sd5000, 4'd9, 8'd16, 1'b1, 1000};
        tbl[1] = '{18'sd0, 18'sd0, 4'd10, 8'd16, 1'b1, 45440};
        tbl[2] = '{18'sd100, 18'sd2560, 4'd0, 8'd32, 1'b1, 1820};
        tbl[3] = '{-18'sd2000, 18'sd30000, 4'd15, 8'd8, 1'b0, -1000};
        tbl[4] = '{18'sd0, -18'sd1024, 4'd0, 8'd16, 1'b1, 500};
        tbl[5] = '{18'sd50, -18'sd256, 4'd1, 8'd255, 1'b1, 13228};
        tbl[6] = '{-18'sd1, -18'sd1, 4'd0, 8'd1, 1'b1, -1};

        repeat (3) @(posedge clock);
        #1;
        check("reset_fm_out", fm_out, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 7; i++)
            run($sformatf("vec%0d", i), tbl[i].m, tbl[i].d, tbl[i].p, tbl[i].f, tbl[i].s, tbl[i].exp);

        mono = 18'sd300; diff = '0; kp = '0; kf = 8'd16; stereo_en = 1'b0; clken = 1'b1;
        np = 0; lat = -1; got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            clken = (k == 5);
            if (k == 5) mono = 18'sd999;
            if (out_valid) begin
                np++;
                lat = k;
                got = fm_out;
            end
        end
        check("overrun_flag", overrun, 1);
        check("overrun_pulses", np, 1);
        check("overrun_value", got, 300);
        check("overrun_latency", lat, 33);
        n_samp++;
        run("overrun_phase_once", 18'sd0, 18'sd0, 4'd1, 8'd16, 1'b1, -8000);

        mono = 18'sd5; kp = 4'd1; kf = 8'd16; stereo_en = 1'b1; clken = 1'b1;
        @(posedge clock); #1;
        clken = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("abort_fm_out", fm_out, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        reset = 1'b0;
        np = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (out_valid) np++;
        end
        check("abort_no_valid", np, 0);
        n_samp = 0;
        run("restart_phase0", 18'sd7, 18'sd0, 4'd1, 8'd16, 1'b1, 7);
        run("restart_phase1", 18'sd0, 18'sd0, 4'd1, 8'd16, 1'b1, 4544);

        for (int i = 0; i < 200; i++) begin
            rm = 18'($urandom);
            rd = 18'($urandom);
            rp = 4'($urandom);
            rf = 8'($urandom);
            rs = $urandom_range(0, 3) != 0;
            run($sformatf("rand%0d", i), rm, rd, rp, rf, rs, model(n_samp, rm, rd, rp, rf, rs));
        end
        check("rand_overrun", overrun, 0);

        mono2 = 18'sd131071; kf2 = 8'd255; stereo2 = 1'b0; clken2 = 1'b1;
        np = 0; got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            clken2 = 1'b0;
            if (out_valid2) begin
                np++;
                got = fm_out2;
            end
        end
        check("sat_pos", got, 8388607);
        check("sat_pos_pulses", np, 1);
        mono2 = -18'sd131072; clken2 = 1'b1;
        np = 0; got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            clken2 = 1'b0;
            if (out_valid2) begin
                np++;
                got = fm_out2;
            end
        end
        check("sat_neg", got, -8388608);
        check("sat_neg_pulses", np, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
